// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard arbitration, memory wait
// states, halt drain, stall-cycle counter and data-memory timeout watchdog.
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ID_Rs,
    input  logic [3:0]       ID_Rt,
    input  logic             ID_uses_Rt,
    input  logic             ID_halt,
    input  logic             EX_MemRead,
    input  logic [3:0]       EX_dstReg,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             WB_halt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_MEM_STALL = 2'd1;
    localparam logic [1:0] S_DRAIN     = 2'd2;
    localparam logic [1:0] S_HALTED    = 2'd3;

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] busy_cnt;
    logic             lu_haz;

    assign lu_haz = EX_MemRead && (EX_dstReg != 4'd0) &&
                    ((ID_Rs == EX_dstReg) || (ID_uses_Rt && (ID_Rt == EX_dstReg)));

    assign halted = (state == S_HALTED);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        state_nxt    = state;

        if (!rst) begin
            if (state == S_HALTED) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
            end else begin
                // A released memory stall behaves exactly like RUN this cycle
                if (state == S_MEM_STALL) begin
                    state_nxt = S_RUN;
                end

                if (dmem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                    if (state != S_DRAIN) begin
                        state_nxt = S_MEM_STALL;
                    end
                end else if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (lu_haz) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (imem_busy) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                end else if (ID_halt && (state != S_DRAIN)) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    state_nxt   = S_DRAIN;
                end

                if (state == S_DRAIN) begin
                    if (!dmem_busy) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                    end
                    if (WB_halt) begin
                        state_nxt = S_HALTED;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            busy_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;

            // Counts consecutive busy edges, including the one that enters the stall
            if ((state != S_HALTED) && dmem_busy) begin
                if (busy_cnt != TMO_LIMIT) begin
                    busy_cnt <= busy_cnt + 1'b1;
                end
                if (busy_cnt >= TMO_LIMIT - 1'b1) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                busy_cnt <= '0;
            end

            if (((state == S_RUN) || (state == S_MEM_STALL)) && !pc_write &&
                (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 4;
    localparam int STALL_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       ID_Rs, ID_Rt, EX_dstReg;
    logic             ID_uses_Rt, ID_halt, EX_MemRead, branch_taken;
    logic             imem_busy, dmem_busy, WB_halt;
    logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic             ex_mem_write, mem_wb_write, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: only "draining" and "halted" matter behaviourally
    bit m_drain, m_halted, m_tmo;
    int m_busy, m_stall;
    bit e_pc, e_ifw, e_fl, e_idw, e_bub, e_exw, e_mww, e_haz;

    // values sampled at the last checked negedge
    logic s_pc, s_ifw, s_fl, s_bub, s_exw, s_halted, s_tmo;
    logic [CNT_W-1:0] s_stall;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt),
        .ID_halt(ID_halt), .EX_MemRead(EX_MemRead), .EX_dstReg(EX_dstReg),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .WB_halt(WB_halt), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urt, input bit idh,
                          input bit mr, input int dst, input bit br, input bit im,
                          input bit dm, input bit wbh);
        ID_Rs = 4'(rs); ID_Rt = 4'(rt); ID_uses_Rt = urt; ID_halt = idh;
        EX_MemRead = mr; EX_dstReg = 4'(dst); branch_taken = br;
        imem_busy = im; dmem_busy = dm; WB_halt = wbh;
    endtask

    task automatic predict();
        e_haz = EX_MemRead && EX_dstReg != 0 &&
                (ID_Rs == EX_dstReg || (ID_uses_Rt && ID_Rt == EX_dstReg));
        {e_pc, e_ifw, e_idw, e_exw, e_mww} = 5'b11111;
        e_fl = 0; e_bub = 0;
        if (rst) return;
        if (m_halted || dmem_busy) begin
            {e_pc, e_ifw, e_idw, e_exw, e_mww} = 5'b00000;
            return;
        end
        if (branch_taken)               begin e_fl = 1; e_bub = 1; end
        else if (e_haz)                 begin e_pc = 0; e_ifw = 0; e_bub = 1; end
        else if (imem_busy)             begin e_pc = 0; e_fl = 1; end
        else if (ID_halt && !m_drain)   begin e_pc = 0; e_fl = 1; end
        if (m_drain) begin e_pc = 0; e_fl = 1; end
    endtask

    task automatic update();
        if (rst) begin
            m_drain = 0; m_halted = 0; m_tmo = 0; m_busy = 0; m_stall = 0;
            return;
        end
        if (m_halted) return;
        if (!m_drain && !e_pc && m_stall < STALL_MAX) m_stall++;
        if (dmem_busy) begin
            m_busy++;
            if (m_busy >= MEM_TIMEOUT) m_tmo = 1;
        end else begin
            m_busy = 0;
        end
        if (m_drain) begin
            if (WB_halt) begin m_halted = 1; m_drain = 0; end
        end else if (!dmem_busy && !branch_taken && !e_haz && !imem_busy && ID_halt) begin
            m_drain = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        predict();
        s_pc = pc_write; s_ifw = if_id_write; s_fl = if_id_flush; s_bub = id_ex_bubble;
        s_exw = ex_mem_write; s_halted = halted; s_tmo = mem_timeout; s_stall = stall_cycles;
        chk("pc_write",     pc_write,     e_pc);
        chk("if_id_write",  if_id_write,  e_ifw);
        chk("if_id_flush",  if_id_flush,  e_fl);
        chk("id_ex_write",  id_ex_write,  e_idw);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("ex_mem_write", ex_mem_write, e_exw);
        chk("mem_wb_write", mem_wb_write, e_mww);
        chk("halted",       halted,       m_halted);
        chk("mem_timeout",  mem_timeout,  m_tmo);
        chk("stall_cycles", stall_cycles, m_stall);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        int burst;
        int halt_age;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        update();
        #1;
        do_reset();
        chk("rst_stall", s_stall, 0);
        chk("rst_pc", s_pc, 1);

        // T1: load-use on Rs, then hazard clears
        set_in(3, 0, 0, 0, 1, 3, 0, 0, 0, 0); cycle();
        chk("t1_pc", s_pc, 0); chk("t1_ifw", s_ifw, 0); chk("t1_bub", s_bub, 1);
        set_in(3, 0, 0, 0, 0, 3, 0, 0, 0, 0); cycle();
        chk("t1_pc_after", s_pc, 1); chk("t1_stall", s_stall, 1);
        // T2: destination R0 never stalls
        set_in(0, 0, 1, 0, 1, 0, 0, 0, 0, 0); cycle();
        chk("t2_pc", s_pc, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("t2_stall", s_stall, 1);
        // T3: taken branch beats load-use on Rt
        set_in(1, 5, 1, 0, 1, 5, 1, 0, 0, 0); cycle();
        chk("t3_pc", s_pc, 1); chk("t3_fl", s_fl, 1); chk("t3_bub", s_bub, 1);

        // T4: three busy cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
            chk("t4_exw", s_exw, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("t4_stall", s_stall, 3); chk("t4_tmo", s_tmo, 0); chk("t4_pc", s_pc, 1);

        // T5: timeout sets on the 4th busy edge and sticks
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
            chk("t5_tmo", s_tmo, (i >= MEM_TIMEOUT) ? 1 : 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("t5_sticky", s_tmo, 1);

        // T6: halt drain then halted
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
        chk("t6_pc", s_pc, 0); chk("t6_fl", s_fl, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 2)); cycle();
            chk("t6_drain_fl", s_fl, 1); chk("t6_drain_pc", s_pc, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("t6_halted", s_halted, 1); chk("t6_pc_halt", s_pc, 0);
        chk("t6_stall", s_stall, 1);

        // stall counter saturates without wrapping
        do_reset();
        for (int i = 0; i < STALL_MAX + 8; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        end
        chk("sat_stall", s_stall, STALL_MAX);

        // randomized traffic
        do_reset();
        burst = 0;
        halt_age = 0;
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 7);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), (burst != 0),
                   ($urandom_range(0, 7) == 0));
            if (burst != 0) burst--;
            halt_age = m_halted ? halt_age + 1 : 0;
            rst = ($urandom_range(0, 299) == 0) || (halt_age > 4);
            cycle();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
